// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: control and pin-side bundle of the multi-channel PWM.
//   master : register/control side (drives config and duty writes, sees outputs)
//   slave  : the PWM engine
// Signals: enable, prescale, center_mode, invert, duty_we, duty_wdata
//          (control -> engine); pwm_out, period_start (engine -> pins/control).
`timescale 1ns/1ps
interface pwm_multi_channel_if #(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 8
);
  logic                            enable;
  logic [PRESCALE_WIDTH-1:0]       prescale;
  logic                            center_mode;
  logic [NUM_CH-1:0]               invert;
  logic [NUM_CH-1:0]               duty_we;
  logic [NUM_CH*COUNTER_WIDTH-1:0] duty_wdata;
  logic [NUM_CH-1:0]               pwm_out;
  logic                            period_start;

  modport master (
    output enable, prescale, center_mode, invert, duty_we, duty_wdata,
    input  pwm_out, period_start
  );

  modport slave (
    input  enable, prescale, center_mode, invert, duty_we, duty_wdata,
    output pwm_out, period_start
  );
endinterface

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: one shared prescaled period counter feeding NUM_CH
// compare channels with double-buffered duty, per-channel polarity,
// edge/center-aligned counting and a period-start strobe.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : pwm_multi_channel_if.slave (config, duty writes, pwm_out, period_start)
`timescale 1ns/1ps
module pwm_multi_channel #(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_multi_channel_if.slave   bus
);
  localparam logic [COUNTER_WIDTH-1:0] MAX = '1;

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [COUNTER_WIDTH-1:0]  cnt, cnt_next;
  logic                      dir_up, dir_next;
  logic                      mode;
  logic                      tick, boundary;
  logic [COUNTER_WIDTH-1:0]  shadow   [NUM_CH];
  logic [COUNTER_WIDTH-1:0]  active   [NUM_CH];
  logic [COUNTER_WIDTH-1:0]  duty_src [NUM_CH];
  logic [NUM_CH-1:0]         pwm_q, pwm_next;
  logic                      start_q;

  always_comb begin
    tick     = bus.enable && (pre_cnt == bus.prescale);
    cnt_next = cnt;
    dir_next = dir_up;
    if (tick) begin
      if (!mode) begin
        cnt_next = cnt + 1'b1;
        dir_next = 1'b1;
      end else if (dir_up) begin
        cnt_next = cnt + 1'b1;
        if (cnt_next == MAX) dir_next = 1'b0;
      end else begin
        cnt_next = cnt - 1'b1;
        if (cnt_next == '0) dir_next = 1'b1;
      end
    end
    boundary = tick && (cnt_next == '0);
  end

  // Value the active duty takes when it reloads: a write on the same cycle
  // wins over the shadow so a boundary-cycle write is not lost for a period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      duty_src[i] = bus.duty_we[i] ? bus.duty_wdata[i*COUNTER_WIDTH +: COUNTER_WIDTH]
                                   : shadow[i];
      pwm_next[i] = (cnt < active[i]) ^ bus.invert[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      cnt     <= '0;
      dir_up  <= 1'b1;
      mode    <= 1'b0;
      pwm_q   <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.duty_we[i]) shadow[i] <= bus.duty_wdata[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
      if (!bus.enable) begin
        pre_cnt <= '0;
        cnt     <= '0;
        dir_up  <= 1'b1;
        mode    <= bus.center_mode;
        pwm_q   <= bus.invert;
        start_q <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) active[i] <= duty_src[i];
      end else begin
        // >= also covers a prescale lowered below the running count.
        pre_cnt <= (pre_cnt >= bus.prescale) ? '0 : pre_cnt + 1'b1;
        cnt     <= cnt_next;
        dir_up  <= dir_next;
        start_q <= boundary;
        pwm_q   <= pwm_next;
        if (boundary) begin
          mode <= bus.center_mode;
          for (int i = 0; i < NUM_CH; i++) active[i] <= duty_src[i];
        end
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = start_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.NUM_CH(4), .COUNTER_WIDTH(8), .PRESCALE_WIDTH(8)) bus ();

  pwm_multi_channel #(.NUM_CH(4), .COUNTER_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]       ps;
    logic             cm;
    logic [3:0]       inv;
    logic [31:0]      duty;   // {ch3, ch2, ch1, ch0}
    logic [15:0]      len;    // clocks between period_start pulses
    logic [3:0][15:0] hi;     // high clocks per period, per channel
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Call right at a period_start sample; returns the clocks to the next one
  // and per-channel high counts over that span. Optionally drives a duty
  // write / mode change at sample act_at (applied on the following edge).
  task automatic run_window(input int act_at, input logic [3:0] we, input logic [31:0] wd,
                            input logic cm_set, output int len, output logic [3:0][15:0] hi);
    len = 0;
    hi  = '0;
    for (int s = 1; s <= 3000; s++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (bus.pwm_out[c]) hi[c] = hi[c] + 16'd1;
      if (s == act_at + 1) bus.duty_we = '0;
      if (s == act_at) begin
        bus.duty_we     = we;
        bus.duty_wdata  = wd;
        bus.center_mode = cm_set;
      end
      if (bus.period_start) begin
        len = s;
        break;
      end
    end
  endtask

  vec_t             vecs [7];
  int               len;
  logic [3:0][15:0] hi;
  bit               ok;
  int               cnt_lo, bad;

  initial begin
    vecs[0] = '{ps:8'd0, cm:1'b0, inv:4'h0, duty:{8'd0,  8'd0,   8'd0,   8'd64},
                len:16'd256, hi:{16'd0,   16'd0,   16'd0,   16'd64}};
    vecs[1] = '{ps:8'd2, cm:1'b0, inv:4'h0, duty:{8'd0,  8'd0,   8'd128, 8'd0},
                len:16'd768, hi:{16'd0,   16'd0,   16'd384, 16'd0}};
    vecs[2] = '{ps:8'd0, cm:1'b1, inv:4'h0, duty:{8'd0,  8'd100, 8'd0,   8'd0},
                len:16'd510, hi:{16'd0,   16'd199, 16'd0,   16'd0}};
    vecs[3] = '{ps:8'd0, cm:1'b0, inv:4'h8, duty:{8'd50, 8'd0,   8'd0,   8'd0},
                len:16'd256, hi:{16'd206, 16'd0,   16'd0,   16'd0}};
    vecs[4] = '{ps:8'd0, cm:1'b0, inv:4'h0, duty:{8'd0,  8'd0,   8'd255, 8'd255},
                len:16'd256, hi:{16'd0,   16'd0,   16'd255, 16'd255}};
    vecs[5] = '{ps:8'd0, cm:1'b1, inv:4'h0, duty:{8'd0,  8'd0,   8'd255, 8'd1},
                len:16'd510, hi:{16'd0,   16'd0,   16'd509, 16'd1}};
    vecs[6] = '{ps:8'd1, cm:1'b0, inv:4'h6, duty:{8'd4,  8'd3,   8'd2,   8'd1},
                len:16'd512, hi:{16'd8,   16'd506, 16'd508, 16'd2}};

    rst_n           = 1'b0;
    bus.enable      = 1'b0;
    bus.prescale    = '0;
    bus.center_mode = 1'b0;
    bus.invert      = '0;
    bus.duty_we     = '0;
    bus.duty_wdata  = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(bus.pwm_out), 0);
    check("reset_period_start", int'(bus.period_start), 0);
    rst_n = 1'b1;

    // Idle level follows invert, then ch3 stays low for duty ticks after enable.
    bus.invert     = 4'b1000;
    bus.duty_we    = 4'b1000;
    bus.duty_wdata = {8'd10, 24'd0};
    @(negedge clk);
    bus.duty_we = '0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.pwm_out != 4'b1000 || bus.period_start) bad++;
    end
    check("idle_inverted_bad_samples", bad, 0);
    bus.enable = 1'b1;
    cnt_lo = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.pwm_out[3]) break;
      cnt_lo++;
    end
    check("inv_ch3_low_clocks_after_enable", cnt_lo, 10);
    check("inv_ch3_high_after_duty", int'(bus.pwm_out[3]), 1);

    foreach (vecs[v]) begin
      bus.enable      = 1'b0;
      bus.prescale    = vecs[v].ps;
      bus.center_mode = vecs[v].cm;
      bus.invert      = vecs[v].inv;
      bus.duty_we     = 4'hf;
      bus.duty_wdata  = vecs[v].duty;
      @(negedge clk);
      bus.duty_we = '0;
      @(negedge clk);
      check($sformatf("v%0d_idle_out", v), int'(bus.pwm_out), int'(vecs[v].inv));
      bus.enable = 1'b1;
      wait_ps(3000, ok);
      check($sformatf("v%0d_first_period_start", v), int'(ok), 1);
      run_window(-1, 4'h0, 32'h0, vecs[v].cm, len, hi);
      check($sformatf("v%0d_period_len", v), len, int'(vecs[v].len));
      for (int c = 0; c < 4; c++)
        check($sformatf("v%0d_ch%0d_high", v, c), int'(hi[c]), int'(vecs[v].hi[c]));
    end

    // Double-buffered duty, boundary bypass and deferred mode change on ch0.
    bus.enable      = 1'b0;
    bus.prescale    = '0;
    bus.center_mode = 1'b0;
    bus.invert      = '0;
    bus.duty_we     = 4'hf;
    bus.duty_wdata  = {24'd0, 8'd64};
    @(negedge clk);
    bus.duty_we = '0;
    bus.enable  = 1'b1;
    wait_ps(3000, ok);
    check("upd_first_period_start", int'(ok), 1);
    run_window(30, 4'b0001, {24'd0, 8'd200}, 1'b0, len, hi);
    check("upd_mid_write_len", len, 256);
    check("upd_mid_write_keeps_old_duty", int'(hi[0]), 64);
    run_window(255, 4'b0001, {24'd0, 8'd10}, 1'b0, len, hi);
    check("upd_next_period_len", len, 256);
    check("upd_next_period_new_duty", int'(hi[0]), 200);
    run_window(100, 4'b0000, {24'd0, 8'd10}, 1'b1, len, hi);
    check("upd_bypass_len_mode_deferred", len, 256);
    check("upd_bypass_duty", int'(hi[0]), 10);
    run_window(-1, 4'b0000, 32'h0, 1'b1, len, hi);
    check("upd_center_len", len, 510);
    check("upd_center_high", int'(hi[0]), 19);

    // Mid-period reset while ch0 is high.
    bus.center_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_ch0_high", int'(bus.pwm_out[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_pwm_out", int'(bus.pwm_out), 0);
    check("midreset_period_start", int'(bus.period_start), 0);
    bad = 0;
    ok  = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.pwm_out != 4'b0000) bad++;
      if (bus.period_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("postreset_outputs_low", bad, 0);
    check("postreset_period_start_seen", int'(ok), 1);
    run_window(-1, 4'h0, 32'h0, 1'b0, len, hi);
    check("postreset_edge_len", len, 256);
    check("postreset_ch0_high", int'(hi[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
